// File: rtl/led_chase_ctrl.sv
// LED chase sequencer: debounced buttons drive a start/pause/stop FSM that paces step/clear pulses for an LED shifter.
// Optional feature: define LED_CHASE_AUTO_REVERSE_EN to bounce direction every 8 steps.
module led_chase_ctrl #(
    parameter logic [31:0] DEB_CNT     = 32'd1_000_000,
    parameter logic [31:0] BASE_PERIOD = 32'd25_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_start,
    input  logic       btn_pause,
    input  logic       btn_stop,
    input  logic       btn_dir,
    input  logic       btn_speed,
    output logic       step,
    output logic       dir,
    output logic       clear,
    output logic [1:0] state,
    output logic [1:0] speed
);

    // state    | meaning
    // ST_IDLE  | stopped, tick counter held at 0
    // ST_RUN   | stepping at BASE_PERIOD >> speed
    // ST_PAUSE | stepping suspended, tick counter frozen
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam int B_START = 0;
    localparam int B_PAUSE = 1;
    localparam int B_STOP  = 2;
    localparam int B_DIR   = 3;
    localparam int B_SPEED = 4;
    localparam int NB      = 5;

    localparam logic [31:0] DEB_TC = (DEB_CNT == 32'd0) ? 32'd0 : DEB_CNT - 32'd1;

    logic [NB-1:0] btn_raw;
    logic [NB-1:0] sync_1;
    logic [NB-1:0] sync_2;
    logic [NB-1:0] deb_lvl;
    logic [NB-1:0] deb_lvl_d;
    logic [NB-1:0] press;
    logic [31:0]   deb_cnt [NB];

    state_t      state_q;
    state_t      state_nxt;
    logic [31:0] tick_q;
    logic [31:0] period_sh;
    logic [31:0] tick_tc;
    logic [1:0]  speed_q;
    logic [2:0]  pos_q;
    logic        dir_q;
    logic        auto_flip;
    logic        start_p;
    logic        pause_p;
    logic        stop_p;

    assign btn_raw = {btn_speed, btn_dir, btn_stop, btn_pause, btn_start};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= btn_raw;
            sync_2 <= sync_1;
        end
    end

    // deb_cnt counts consecutive samples that disagree with the accepted level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_lvl   <= '0;
            deb_lvl_d <= '0;
            for (int i = 0; i < NB; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            deb_lvl_d <= deb_lvl;
            for (int i = 0; i < NB; i++) begin
                if (sync_2[i] == deb_lvl[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] >= DEB_TC) begin
                    deb_lvl[i] <= sync_2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 32'd1;
                end
            end
        end
    end

    assign press   = deb_lvl & ~deb_lvl_d;
    assign start_p = press[B_START];
    assign pause_p = press[B_PAUSE];
    assign stop_p  = press[B_STOP];

    always_comb begin
        state_nxt = state_q;
        clear     = 1'b0;
        if (stop_p) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_p) begin
                        state_nxt = ST_RUN;
                        clear     = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (pause_p) state_nxt = ST_PAUSE;
                end
                ST_PAUSE: begin
                    if (start_p) state_nxt = ST_RUN;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_nxt;
    end

    // A shifted period of 0 collapses to 1 so the terminal count stays at 0
    assign period_sh = BASE_PERIOD >> speed_q;
    assign tick_tc   = (period_sh == 32'd0) ? 32'd0 : period_sh - 32'd1;
    assign step      = (state_q == ST_RUN) && (tick_q == tick_tc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q <= '0;
        end else if (press[B_SPEED] || state_q == ST_IDLE) begin
            tick_q <= '0;
        end else if (state_q == ST_RUN) begin
            tick_q <= step ? 32'd0 : tick_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            speed_q <= '0;
            pos_q   <= '0;
        end else begin
            speed_q <= speed_q + {1'b0, press[B_SPEED]};
            if (clear)     pos_q <= '0;
            else if (step) pos_q <= pos_q + 3'd1;
        end
    end

`ifdef LED_CHASE_AUTO_REVERSE_EN
    assign auto_flip = step && (pos_q == 3'd7);
`else
    assign auto_flip = 1'b0;
`endif

    // A dir press coinciding with an auto bounce cancels it via the XOR
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dir_q <= 1'b0;
        else        dir_q <= dir_q ^ press[B_DIR] ^ auto_flip;
    end

    assign dir   = dir_q;
    assign state = state_q;
    assign speed = speed_q;

endmodule

// File: tb/tb_led_chase_ctrl.sv
// Bench for led_chase_ctrl: cycle-accurate behavioural model plus directed and randomized button stimulus.
module tb_led_chase_ctrl;

    localparam int DEB  = 4;
    localparam int BASE = 16;
`ifdef LED_CHASE_AUTO_REVERSE_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] raw   = '0;
    logic       step, dir, clear;
    logic [1:0] state, speed;

    always #5 clk = ~clk;

    led_chase_ctrl #(.DEB_CNT(DEB), .BASE_PERIOD(BASE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_start (raw[0]),
        .btn_pause (raw[1]),
        .btn_stop  (raw[2]),
        .btn_dir   (raw[3]),
        .btn_speed (raw[4]),
        .step      (step),
        .dir       (dir),
        .clear     (clear),
        .state     (state),
        .speed     (speed)
    );

    typedef struct packed {
        logic [4:0]      s1;
        logic [4:0]      s2;
        logic [4:0]      deb;
        logic [4:0]      deb_prev;
        logic [4:0][7:0] run;
        logic [1:0]      st;
        logic [31:0]     tick;
        logic [1:0]      spd;
        logic [2:0]      pos;
        logic            dir;
    } mdl_t;

    mdl_t m = '0;

    function automatic int eff_period(logic [1:0] spd);
        int p;
        p = BASE >> spd;
        if (p < 1) p = 1;
        return p;
    endfunction

    // returns {state, speed, dir, step, clear}
    function automatic logic [6:0] mdl_out(mdl_t x);
        logic [4:0] pr;
        logic stp, clr;
        pr  = x.deb & ~x.deb_prev;
        stp = (x.st == 2'd1) && (int'(x.tick) == eff_period(x.spd) - 1);
        clr = (x.st == 2'd0) && pr[0] && !pr[2];
        return {x.st, x.spd, x.dir, stp, clr};
    endfunction

    function automatic mdl_t next_mdl(mdl_t x, logic [4:0] r);
        mdl_t n;
        logic [4:0] pr;
        int period;
        logic stp, clr;
        n = x;
        n.s1 = r;
        n.s2 = x.s1;
        for (int b = 0; b < 5; b++) begin
            if (x.s2[b] != x.deb[b]) begin
                if (int'(x.run[b]) + 1 >= DEB) begin
                    n.deb[b] = x.s2[b];
                    n.run[b] = '0;
                end else begin
                    n.run[b] = x.run[b] + 8'd1;
                end
            end else begin
                n.run[b] = '0;
            end
        end
        n.deb_prev = x.deb;
        pr     = x.deb & ~x.deb_prev;
        period = eff_period(x.spd);
        stp    = (x.st == 2'd1) && (int'(x.tick) == period - 1);
        clr    = (x.st == 2'd0) && pr[0] && !pr[2];
        if (pr[2])                      n.st = 2'd0;
        else if (pr[0] && x.st != 2'd1) n.st = 2'd1;
        else if (pr[1] && x.st == 2'd1) n.st = 2'd2;
        if (pr[4] || x.st == 2'd0) n.tick = '0;
        else if (x.st == 2'd1)     n.tick = 32'((int'(x.tick) + 1) % period);
        n.spd = 2'((int'(x.spd) + int'(pr[4])) % 4);
        if (clr)      n.pos = '0;
        else if (stp) n.pos = 3'((int'(x.pos) + 1) % 8);
        n.dir = x.dir ^ pr[3] ^ (AUTO && stp && x.pos == 3'd7);
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else        m <= next_mdl(m, raw);
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int clear_cnt = 0, step_cnt = 0, clear_cyc = 0, clr_step_snap = 0;
    int last_step = 0, prev_step = 0, s1_after = -1, s2_after = -1;
    int tog_n = 0;
    int tog_step [64];
    logic prev_dir = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cycle_check();
        logic [6:0] e;
        logic [6:0] a;
        @(negedge clk);
        cyc++;
        e = mdl_out(m);
        a = {state, speed, dir, step, clear};
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL model_cmp cyc %0d: got state=%0d speed=%0d dir=%0d step=%0d clear=%0d, expected state=%0d speed=%0d dir=%0d step=%0d clear=%0d",
                     cyc, a[6:5], a[4:3], a[2], a[1], a[0], e[6:5], e[4:3], e[2], e[1], e[0]);
        end
        if (clear) begin
            clear_cnt++;
            clear_cyc     = cyc;
            clr_step_snap = step_cnt;
            s1_after      = -1;
            s2_after      = -1;
        end
        if (step) begin
            step_cnt++;
            prev_step = last_step;
            last_step = cyc;
            if (s1_after < 0)      s1_after = cyc;
            else if (s2_after < 0) s2_after = cyc;
        end
        if (dir !== prev_dir) begin
            if (tog_n < 64) tog_step[tog_n] = step_cnt;
            tog_n++;
        end
        prev_dir = dir;
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input int n);
        repeat (n) cycle_check();
    endtask

    task automatic press(input logic [4:0] mask, input int hold);
        raw = mask;
        tick(hold);
        raw = '0;
        tick(10);
    endtask

    initial begin
        int sc, cc, tb0, steps_after, mask;
        for (int i = 0; i < 64; i++) tog_step[i] = 0;

        tick(3);
        chk("rst_state", int'(state), 0);
        chk("rst_step", int'(step), 0);
        chk("rst_clear", int'(clear), 0);
        chk("rst_dir", int'(dir), 0);
        chk("rst_speed", int'(speed), 0);
        rst_n = 1'b1;
        tick(2);

        raw[0] = 1'b1;
        tick(2);
        raw = '0;
        tick(15);
        chk("glitch_state", int'(state), 0);
        chk("glitch_clear", clear_cnt, 0);

        press(5'b00001, 10);
        tick(40);
        chk("start_clear_cnt", clear_cnt, 1);
        chk("start_state", int'(state), 1);
        chk("first_step_lat", s1_after - clear_cyc, 16);
        chk("step_period_s0", s2_after - s1_after, 16);

        repeat (3) press(5'b10000, 6);
        chk("speed3", int'(speed), 3);
        tick(8);
        chk("step_period_s3", last_step - prev_step, 2);
        press(5'b10000, 6);
        chk("speed_wrap", int'(speed), 0);
        tick(40);
        chk("step_period_wrap", last_step - prev_step, 16);

        press(5'b00010, 6);
        chk("pause_state", int'(state), 2);
        sc = step_cnt;
        tick(20);
        chk("pause_no_step", step_cnt, sc);
        cc = clear_cnt;
        press(5'b00001, 6);
        chk("resume_state", int'(state), 1);
        chk("resume_no_clear", clear_cnt, cc);
        tick(12);

        press(5'b00101, 6);
        chk("stop_start_state", int'(state), 0);
        chk("stop_start_no_clear", clear_cnt, cc);
        sc = step_cnt;
        tick(40);
        chk("stop_no_step", step_cnt, sc);

        repeat (3) press(5'b10000, 6);
        chk("idle_speed3", int'(speed), 3);
        tb0 = tog_n;
        press(5'b00001, 10);
        tick(40);
        steps_after = step_cnt - clr_step_snap;
        chk("bounce_steps_ge24", int'(steps_after >= 24), 1);
        chk("dir_toggles", tog_n - tb0, AUTO ? steps_after / 8 : 0);
        for (int k = 0; k < tog_n - tb0 && k < 3; k++)
            chk("toggle_step", tog_step[tb0 + k] - clr_step_snap, 8 * (k + 1));

        press(5'b01000, 6);
        chk("pre_rst_state", int'(state), 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_state", int'(state), 0);
        chk("async_step", int'(step), 0);
        chk("async_clear", int'(clear), 0);
        chk("async_dir", int'(dir), 0);
        chk("async_speed", int'(speed), 0);
        tick(2);
        rst_n = 1'b1;
        tick(2);

        for (int i = 0; i < 150; i++) begin
            mask = $urandom_range(0, 31);
            if ($urandom_range(0, 3) != 0) mask[2] = 1'b0;
            raw = 5'(mask);
            tick($urandom_range(1, 12));
            if ($urandom_range(0, 1) == 0) raw = '0;
            tick($urandom_range(0, 8));
            if (i % 37 == 36) begin
                rst_n = 1'b0;
                tick(2);
                rst_n = 1'b1;
            end
        end
        raw = '0;
        tick(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
